// File: rtl/sap_clock_module.sv
// ---------------------------------------------------------------------------
// sap_clock_module
//
// Purpose:
//   Generates the CPU clock for the SAP-U datapath. In auto mode cpu_clk is
//   a free-running 50% duty clock with a half-period of AUTO_DIV clk cycles.
//   In manual mode each debounced press of the step button produces exactly
//   one high pulse of STEP_HIGH clk cycles. A halt request freezes cpu_clk
//   low. All outputs are flops, so cpu_clk is glitch-free.
//
// Parameters:
//   AUTO_DIV        half-period of cpu_clk in auto mode, clk cycles (>=1)
//   DEBOUNCE_CYCLES stable synchronized samples to accept a button change (>=2)
//   STEP_HIGH       cpu_clk high time per manual step, clk cycles (>=1)
//
// Ports:
//   clk          in  system clock, all logic on posedge
//   rst_n        in  asynchronous active-low reset
//   manual_mode  in  1 = single-step, 0 = auto (asynchronous switch)
//   step_btn     in  raw active-high pushbutton (bouncy, asynchronous)
//   halt         in  HLT level from control logic (asynchronous)
//   cpu_clk      out registered CPU clock
//   cpu_clk_rise out one-clk pulse in the first cycle cpu_clk is high
//   halted       out high while cpu_clk is held low by halt
// ---------------------------------------------------------------------------
module sap_clock_module #(
    parameter int AUTO_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STEP_HIGH       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic manual_mode,
    input  logic step_btn,
    input  logic halt,
    output logic cpu_clk,
    output logic cpu_clk_rise,
    output logic halted
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int DIV_MAX = (AUTO_DIV > STEP_HIGH) ? AUTO_DIV : STEP_HIGH;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] AUTO_LAST = DIV_W'(AUTO_DIV - 1);
    localparam logic [DIV_W-1:0] STEP_LAST = DIV_W'(STEP_HIGH - 1);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    // 2-FF synchronizers for the asynchronous inputs
    logic [1:0] r_mode_sync;
    logic [1:0] r_step_sync;
    logic [1:0] r_halt_sync;
    // Start-up delay: the divider waits until the synchronizers have been
    // filled with real input samples, so the first auto rise after reset
    // lines up with the synchronizer latency.
    logic [1:0] r_run;

    logic w_mode_s;
    logic w_step_s;
    logic w_halt_s;
    logic w_run;

    assign w_mode_s = r_mode_sync[1];
    assign w_step_s = r_step_sync[1];
    assign w_halt_s = r_halt_sync[1];
    assign w_run    = r_run[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_sync <= 2'b00;
            r_step_sync <= 2'b00;
            r_halt_sync <= 2'b00;
            r_run       <= 2'b00;
        end else begin
            r_mode_sync <= {r_mode_sync[0], manual_mode};
            r_step_sync <= {r_step_sync[0], step_btn};
            r_halt_sync <= {r_halt_sync[0], halt};
            r_run       <= {r_run[0], 1'b1};
        end
    end

    // Debouncer: any sample equal to the accepted level restarts the count,
    // so a change is accepted only after DEBOUNCE_CYCLES differing samples
    // in a row. The step pulse is raised together with the accepted press.
    logic [DB_W-1:0] r_db_cnt;
    logic            r_btn_db;
    logic            r_step_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt     <= '0;
            r_btn_db     <= 1'b0;
            r_step_pulse <= 1'b0;
        end else if (w_step_s == r_btn_db) begin
            r_db_cnt     <= '0;
            r_step_pulse <= 1'b0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt     <= '0;
            r_btn_db     <= w_step_s;
            r_step_pulse <= w_step_s;
        end else begin
            r_db_cnt     <= r_db_cnt + DB_W'(1);
            r_step_pulse <= 1'b0;
        end
    end

    // Clock FSM
    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic             r_auto_hi;
    logic             w_auto_hi_nxt;
    logic [DIV_W-1:0] w_high_last;

    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div;
        w_auto_hi_nxt = r_auto_hi;
        w_high_last   = r_auto_hi ? AUTO_LAST : STEP_LAST;
        case (r_state)
            ST_LOW: begin
                // While halted (and for the cycle halted clears) the divider
                // stays at 0, so the first LOW phase after a halt is full length.
                if (!w_run || w_halt_s || halted) begin
                    w_div_nxt = '0;
                end else if (!w_mode_s) begin
                    if (r_div == AUTO_LAST) begin
                        w_state_nxt   = ST_HIGH;
                        w_div_nxt     = '0;
                        w_auto_hi_nxt = 1'b1;
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                end else begin
                    w_div_nxt = '0;
                    if (r_step_pulse) begin
                        w_state_nxt   = ST_HIGH;
                        w_auto_hi_nxt = 1'b0;
                    end
                end
            end
            ST_HIGH: begin
                // Length fixed by the mode latched on entry; halt and mode
                // changes are deliberately ignored here.
                if (r_div == w_high_last) begin
                    w_state_nxt = ST_LOW;
                    w_div_nxt   = '0;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_div_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_LOW;
            r_div        <= '0;
            r_auto_hi    <= 1'b0;
            cpu_clk      <= 1'b0;
            cpu_clk_rise <= 1'b0;
            halted       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div        <= w_div_nxt;
            r_auto_hi    <= w_auto_hi_nxt;
            cpu_clk      <= (w_state_nxt == ST_HIGH);
            cpu_clk_rise <= (r_state == ST_LOW) && (w_state_nxt == ST_HIGH);
            halted       <= (w_state_nxt == ST_LOW) && w_halt_s;
        end
    end

endmodule
